// File: rtl/s_stream_unpack_if.sv
// AXI4-Stream beat bus (32-bit data, byte strobes, last) between a source and the unpacker.
// Latency: none, wires only.
// Backpressure: the slave drives tready; a beat transfers on tvalid && tready.
interface s_stream_unpack_if;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tstrb, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tstrb, input tlast, input tvalid, output tready);
endinterface

// File: rtl/s_stream_unpack.sv
// AXI4-Stream 32-bit beat receiver: buffers beats and hands them out as 16-bit halfwords, low half first.
// Latency: beat readable the cycle after acceptance; rd_data appears 1 cycle after rd_en.
// Backpressure: tready drops when the FIFO holds FIFO_DEPTH beats, judged on registered count only.
module s_stream_unpack #(
    parameter int FIFO_DEPTH = 16,
    parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 s00_axis_aclk,
    input  logic                 s00_axis_areset,
    s_stream_unpack_if.slave     s00_axis,
    input  logic                 rd_en,
    output logic [15:0]          rd_data,
    output logic                 rd_valid,
    output logic                 rd_last,
    output logic                 empty,
    output logic [LW-1:0]        level,
    output logic                 strb_err
);
    localparam int AW = $clog2(FIFO_DEPTH);

    // Entry layout: [33] last, [32] two halves valid, [31:0] beat data.
    logic [33:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] count_q;
    logic          sel_q;
    logic [15:0]   rd_data_q;
    logic          rd_valid_q;
    logic          rd_last_q;
    logic          strb_err_q;

    logic          accept;
    logic          rd_fire;
    logic          pop;
    logic          in_two;
    logic          in_bad;
    logic [33:0]   head;

    // Only the exact low-half pattern marks a single-half beat; anything unexpected is kept whole.
    assign in_two  = (s00_axis.tstrb != 4'b0011);
    assign in_bad  = (s00_axis.tstrb != 4'b1111) && (s00_axis.tstrb != 4'b0011);

    assign s00_axis.tready = !s00_axis_areset && (count_q != LW'(FIFO_DEPTH));
    assign accept  = s00_axis.tvalid && s00_axis.tready;

    assign head    = mem_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign rd_fire = rd_en && !empty;
    // The head entry leaves once its final half has been read.
    assign pop     = rd_fire && (sel_q || !head[32]);

    assign level    = count_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign strb_err = strb_err_q;

    // Storage array: no reset needed, stale contents are unreachable once pointers clear.
    always_ff @(posedge s00_axis_aclk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= {s00_axis.tlast, in_two, s00_axis.tdata};
        end
    end

    // Pointers, occupancy, half-select and the registered read port.
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sel_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            strb_err_q <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (accept && in_bad) begin
                strb_err_q <= 1'b1;
            end

            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            rd_valid_q <= rd_fire;
            rd_last_q  <= 1'b0;
            if (rd_fire) begin
                rd_data_q <= sel_q ? head[31:16] : head[15:0];
                rd_last_q <= head[33] && (sel_q || !head[32]);
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                    sel_q    <= 1'b0;
                end else begin
                    sel_q    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_s_stream_unpack.sv
// Directed bench for s_stream_unpack: table of single-cycle vectors plus multi-cycle sequences.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: fill/drain sequences exercise full FIFO and pointer wrap.
module tb_s_stream_unpack;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_last;
    logic        empty;
    logic [4:0]  level;
    logic        strb_err;

    int checks   = 0;
    int failures = 0;

    s_stream_unpack_if axis ();

    s_stream_unpack #(.FIFO_DEPTH(16)) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis        (axis.slave),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .rd_last         (rd_last),
        .empty           (empty),
        .level           (level),
        .strb_err        (strb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] tdata;
        logic [3:0]  tstrb;
        logic        tlast;
        logic        tvalid;
        logic        rd;
        logic        e_vld;
        logic [15:0] e_dat;
        logic        e_last;
        logic        e_empty;
        logic [4:0]  e_level;
        logic        e_err;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] s, input logic l, input logic r);
        axis.tvalid = v;
        axis.tdata  = d;
        axis.tstrb  = s;
        axis.tlast  = l;
        rd_en       = r;
    endtask

    task automatic rd_chk(input string nm, input logic [15:0] d, input logic l);
        drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
        tick();
        chk({nm, "_vld"}, rd_valid, 1'b1);
        chk({nm, "_dat"}, rd_data, d);
        chk({nm, "_last"}, rd_last, l);
    endtask

    initial begin
        vt[0]  = '{32'hBEEF_1234, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd1, 1'b0};
        vt[1]  = '{32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 5'd1, 1'b0};
        vt[2]  = '{32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b1, 5'd0, 1'b0};
        vt[3]  = '{32'hAAAA_5555, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF, 1'b0, 1'b0, 5'd1, 1'b0};
        vt[4]  = '{32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h5555, 1'b1, 1'b1, 5'd0, 1'b0};
        vt[5]  = '{32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h5555, 1'b0, 1'b1, 5'd0, 1'b0};
        vt[6]  = '{32'h1111_2222, 4'hC, 1'b0, 1'b1, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 5'd1, 1'b1};
        vt[7]  = '{32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2222, 1'b0, 1'b0, 5'd1, 1'b1};
        vt[8]  = '{32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b1, 5'd0, 1'b1};
        vt[9]  = '{32'h0000_7777, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1111, 1'b0, 1'b0, 5'd1, 1'b1};
        vt[10] = '{32'h9999_8888, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 16'h7777, 1'b1, 1'b0, 5'd1, 1'b1};
        vt[11] = '{32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8888, 1'b0, 1'b0, 5'd1, 1'b1};
        vt[12] = '{32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b1, 5'd0, 1'b1};

        // Reset held with traffic offered.
        drive(1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_tready", axis.tready, 1'b0);
            chk("rst_empty", empty, 1'b1);
            chk("rst_level", level, 5'd0);
            chk("rst_outs", {rd_data, rd_valid, rd_last, strb_err}, 19'h0);
        end
        rst = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        #1;
        chk("rel_tready", axis.tready, 1'b1);
        tick();
        chk("rel_level", level, 5'd0);
        chk("rel_empty", empty, 1'b1);

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].tvalid, vt[i].tdata, vt[i].tstrb, vt[i].tlast, vt[i].rd);
            tick();
            chk($sformatf("v%0d_vld", i), rd_valid, vt[i].e_vld);
            chk($sformatf("v%0d_dat", i), rd_data, vt[i].e_dat);
            chk($sformatf("v%0d_last", i), rd_last, vt[i].e_last);
            chk($sformatf("v%0d_empty", i), empty, vt[i].e_empty);
            chk($sformatf("v%0d_level", i), level, vt[i].e_level);
            chk($sformatf("v%0d_err", i), strb_err, vt[i].e_err);
            chk($sformatf("v%0d_tready", i), axis.tready, 1'b1);
        end

        // Fill to full, drain one entry, accept the 17th beat, check order across the wrap.
        begin
            int n = 0;
            logic acc;
            for (int c = 0; c < 20; c++) begin
                drive(1'b1, {16'(32'hA000 + n), 16'(32'h5000 + n)}, 4'hF, 1'b0, 1'b0);
                #1;
                acc = axis.tready;
                tick();
                if (acc) n++;
            end
            chk("fill_count", n, 16);
            chk("fill_level", level, 5'd16);
            chk("fill_tready", axis.tready, 1'b0);
            drive(1'b1, {16'hA010, 16'h5010}, 4'hF, 1'b0, 1'b1);
            tick();
            chk("full_rd0_dat", rd_data, 16'h5000);
            chk("full_rd0_level", level, 5'd16);
            chk("full_rd0_tready", axis.tready, 1'b0);
            tick();
            chk("full_rd1_dat", rd_data, 16'hA000);
            chk("full_rd1_level", level, 5'd15);
            chk("full_rd1_tready", axis.tready, 1'b1);
            rd_en = 1'b0;
            tick();
            chk("beat17_level", level, 5'd16);
            chk("beat17_tready", axis.tready, 1'b0);
            for (int k = 1; k <= 16; k++) begin
                rd_chk($sformatf("wrap%0d_lo", k), 16'(32'h5000 + k), 1'b0);
                rd_chk($sformatf("wrap%0d_hi", k), 16'(32'hA000 + k), 1'b0);
            end
            chk("wrap_empty", empty, 1'b1);
        end

        // Simultaneous accept and pop with level 5 and the head half-consumed.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, {16'(32'hC000 + k), 16'(32'h3000 + k)}, 4'hF, 1'b0, 1'b0);
            tick();
        end
        rd_chk("sim_pre", 16'h3000, 1'b0);
        chk("sim_pre_level", level, 5'd5);
        drive(1'b1, {16'hC005, 16'h3005}, 4'hF, 1'b1, 1'b1);
        tick();
        chk("sim_dat", rd_data, 16'hC000);
        chk("sim_level", level, 5'd5);
        rd_chk("sim_sel0", 16'h3001, 1'b0);
        rd_chk("sim_b1hi", 16'hC001, 1'b0);
        for (int k = 2; k <= 5; k++) begin
            rd_chk($sformatf("sim_b%0d_lo", k), 16'(32'h3000 + k), 1'b0);
            rd_chk($sformatf("sim_b%0d_hi", k), 16'(32'hC000 + k), k == 5);
        end
        chk("sim_empty", empty, 1'b1);

        // Reset discards a half-consumed entry and clears the sticky error.
        drive(1'b1, 32'h6666_5555, 4'hF, 1'b1, 1'b0);
        tick();
        rd_chk("pre_rst_lo", 16'h5555, 1'b0);
        chk("pre_rst_err", strb_err, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("post_rst_err", strb_err, 1'b0);
        chk("post_rst_level", level, 5'd0);
        chk("post_rst_empty", empty, 1'b1);
        chk("post_rst_outs", {rd_data, rd_valid, rd_last}, 18'h0);
        drive(1'b1, 32'h4444_3333, 4'hF, 1'b1, 1'b0);
        tick();
        rd_chk("post_rst_lo", 16'h3333, 1'b0);
        rd_chk("post_rst_hi", 16'h4444, 1'b1);
        chk("post_rst_end_empty", empty, 1'b1);
        chk("post_rst_end_err", strb_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
